// File: rtl/aging_round_robin_arbiter.sv
// Round-robin arbiter with a critical tier and per-requester aging that promotes
// long-waiting requesters; the granted payload sits in a registered valid/ack stage.
module aging_round_robin_arbiter #(
   parameter int SINGLE_REQUEST_WIDTH_IN_BITS = 64,
   parameter int NUM_REQUEST                  = 3,
   parameter int AGE_THRESHOLD                = 8,
   localparam int IDX_W = (NUM_REQUEST > 2) ? $clog2(NUM_REQUEST) : 1,
   localparam int AGE_W = $clog2(AGE_THRESHOLD + 1)
) (
   input  logic                                                clk_in,
   input  logic                                                reset_in,
   input  logic [SINGLE_REQUEST_WIDTH_IN_BITS*NUM_REQUEST-1:0] request_flatted_in,
   input  logic [NUM_REQUEST-1:0]                              request_valid_flatted_in,
   input  logic [NUM_REQUEST-1:0]                              request_critical_flatted_in,
   output logic [NUM_REQUEST-1:0]                              issue_ack_out,
   output logic [SINGLE_REQUEST_WIDTH_IN_BITS-1:0]             request_out,
   output logic                                                request_valid_out,
   output logic [IDX_W-1:0]                                    grant_index_out,
   input  logic                                                issue_ack_in
);

   localparam int W = SINGLE_REQUEST_WIDTH_IN_BITS;

   logic [IDX_W-1:0]       last_ptr_r;
   logic [AGE_W-1:0]       age_r [NUM_REQUEST];
   logic [NUM_REQUEST-1:0] eff_crit_s;
   logic [NUM_REQUEST-1:0] ack_s;
   logic                   load_s;
   logic                   crit_found_s;
   logic                   valid_found_s;
   logic [IDX_W-1:0]       crit_idx_s;
   logic [IDX_W-1:0]       valid_idx_s;
   logic [IDX_W-1:0]       sel_s;
   logic [W-1:0]           sel_payload_s;

   // Effective critical: external hint or an age counter that reached the threshold.
   always_comb begin
      eff_crit_s = '0;
      for (int i = 0; i < NUM_REQUEST; i++) begin
         eff_crit_s[i] = request_valid_flatted_in[i] &
                         (request_critical_flatted_in[i] | (age_r[i] == AGE_W'(AGE_THRESHOLD)));
      end
   end

   // Circular search from last_ptr+1; the wrap is a single compare-and-subtract.
   always_comb begin
      int               cand_v;
      logic [IDX_W-1:0] cand_idx_v;
      cand_v        = 0;
      cand_idx_v    = '0;
      crit_found_s  = 1'b0;
      valid_found_s = 1'b0;
      crit_idx_s    = '0;
      valid_idx_s   = '0;
      for (int k = 0; k < NUM_REQUEST; k++) begin
         cand_v        = int'(last_ptr_r) + 1 + k;
         cand_v        = (cand_v >= NUM_REQUEST) ? (cand_v - NUM_REQUEST) : cand_v;
         cand_idx_v    = IDX_W'(cand_v);
         crit_idx_s    = (eff_crit_s[cand_idx_v] & ~crit_found_s) ? cand_idx_v : crit_idx_s;
         crit_found_s  = crit_found_s | eff_crit_s[cand_idx_v];
         valid_idx_s   = (request_valid_flatted_in[cand_idx_v] & ~valid_found_s) ? cand_idx_v : valid_idx_s;
         valid_found_s = valid_found_s | request_valid_flatted_in[cand_idx_v];
      end
   end

   assign sel_s = crit_found_s ? crit_idx_s : valid_idx_s;

   // AND-OR payload mux keyed on the selected index.
   always_comb begin
      sel_payload_s = '0;
      for (int i = 0; i < NUM_REQUEST; i++) begin
         sel_payload_s = sel_payload_s | ({W{sel_s == IDX_W'(i)}} & request_flatted_in[i*W +: W]);
      end
   end

   assign load_s        = ~request_valid_out | issue_ack_in;
   // Reset masks the ack combinationally so no requester sees a handshake during reset.
   assign ack_s         = (load_s & valid_found_s & ~reset_in) ? (NUM_REQUEST'(1'b1) << sel_s) : '0;
   assign issue_ack_out = ack_s;

   // Output stage and round-robin pointer; an empty load drains the stage.
   always_ff @(posedge clk_in or posedge reset_in) begin
      if (reset_in) begin
         request_out       <= '0;
         request_valid_out <= 1'b0;
         grant_index_out   <= '0;
         last_ptr_r        <= IDX_W'(NUM_REQUEST - 1);
      end else if (load_s) begin
         if (valid_found_s) begin
            request_out       <= sel_payload_s;
            request_valid_out <= 1'b1;
            grant_index_out   <= sel_s;
            last_ptr_r        <= sel_s;
         end else begin
            request_out       <= '0;
            request_valid_out <= 1'b0;
            grant_index_out   <= grant_index_out;
            last_ptr_r        <= last_ptr_r;
         end
      end else begin
         request_out       <= request_out;
         request_valid_out <= request_valid_out;
         grant_index_out   <= grant_index_out;
         last_ptr_r        <= last_ptr_r;
      end
   end

   // Age counters track input-side waiting only, regardless of output stall.
   always_ff @(posedge clk_in or posedge reset_in) begin
      if (reset_in) begin
         for (int i = 0; i < NUM_REQUEST; i++) begin
            age_r[i] <= '0;
         end
      end else begin
         for (int i = 0; i < NUM_REQUEST; i++) begin
            if (ack_s[i] | ~request_valid_flatted_in[i]) begin
               age_r[i] <= '0;
            end else if (age_r[i] < AGE_W'(AGE_THRESHOLD)) begin
               age_r[i] <= age_r[i] + AGE_W'(1);
            end else begin
               age_r[i] <= age_r[i];
            end
         end
      end
   end

endmodule

// File: tb/tb_aging_round_robin_arbiter.sv
// Directed, table-driven bench for aging_round_robin_arbiter (3 requesters, threshold 4, 8-bit payloads).
module tb_aging_round_robin_arbiter;

   logic        clk_in;
   logic        reset_in;
   logic [23:0] request_flatted_in;
   logic [2:0]  request_valid_flatted_in;
   logic [2:0]  request_critical_flatted_in;
   logic [2:0]  issue_ack_out;
   logic [7:0]  request_out;
   logic        request_valid_out;
   logic [1:0]  grant_index_out;
   logic        issue_ack_in;

   int checks;
   int failures;

   typedef struct {
      logic [2:0] valid;
      logic [2:0] crit;
      logic       ack_in;
      logic [2:0] exp_ack;
      logic       exp_rv;
      logic [7:0] exp_out;
      logic [1:0] exp_g;
   } vec_t;

   vec_t vecs [23];

   aging_round_robin_arbiter #(
      .SINGLE_REQUEST_WIDTH_IN_BITS(8),
      .NUM_REQUEST(3),
      .AGE_THRESHOLD(4)
   ) dut (
      .clk_in(clk_in),
      .reset_in(reset_in),
      .request_flatted_in(request_flatted_in),
      .request_valid_flatted_in(request_valid_flatted_in),
      .request_critical_flatted_in(request_critical_flatted_in),
      .issue_ack_out(issue_ack_out),
      .request_out(request_out),
      .request_valid_out(request_valid_out),
      .grant_index_out(grant_index_out),
      .issue_ack_in(issue_ack_in)
   );

   initial begin
      clk_in = 1'b0;
      forever #5 clk_in = ~clk_in;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Drive one cycle of inputs, check the combinational ack, then the registered outputs.
   task automatic step(input string name, input logic [2:0] valid, input logic [2:0] crit,
                       input logic ack_in, input logic [2:0] exp_ack, input logic exp_rv,
                       input logic [7:0] exp_out, input logic [1:0] exp_g);
      request_valid_flatted_in    = valid;
      request_critical_flatted_in = crit;
      issue_ack_in                = ack_in;
      #1;
      check({name, ".ack"}, 32'(issue_ack_out), 32'(exp_ack));
      @(posedge clk_in);
      #1;
      check({name, ".rv"}, 32'(request_valid_out), 32'(exp_rv));
      check({name, ".out"}, 32'(request_out), 32'(exp_out));
      check({name, ".grant"}, 32'(grant_index_out), 32'(exp_g));
   endtask

   initial begin
      logic [2:0] age_exp_ack [6];
      logic [1:0] age_exp_g   [6];
      logic [7:0] age_exp_out [6];

      checks   = 0;
      failures = 0;

      vecs[0]  = '{3'b111, 3'b000, 1'b1, 3'b001, 1'b1, 8'hA0, 2'd0};
      vecs[1]  = '{3'b111, 3'b000, 1'b1, 3'b010, 1'b1, 8'hA1, 2'd1};
      vecs[2]  = '{3'b111, 3'b000, 1'b1, 3'b100, 1'b1, 8'hA2, 2'd2};
      vecs[3]  = '{3'b111, 3'b000, 1'b1, 3'b001, 1'b1, 8'hA0, 2'd0};
      vecs[4]  = '{3'b111, 3'b100, 1'b1, 3'b100, 1'b1, 8'hA2, 2'd2};
      vecs[5]  = '{3'b111, 3'b000, 1'b1, 3'b001, 1'b1, 8'hA0, 2'd0};
      vecs[6]  = '{3'b111, 3'b000, 1'b1, 3'b010, 1'b1, 8'hA1, 2'd1};
      vecs[7]  = '{3'b111, 3'b000, 1'b0, 3'b000, 1'b1, 8'hA1, 2'd1};
      vecs[8]  = '{3'b111, 3'b000, 1'b0, 3'b000, 1'b1, 8'hA1, 2'd1};
      vecs[9]  = '{3'b111, 3'b000, 1'b0, 3'b000, 1'b1, 8'hA1, 2'd1};
      vecs[10] = '{3'b111, 3'b000, 1'b0, 3'b000, 1'b1, 8'hA1, 2'd1};
      vecs[11] = '{3'b111, 3'b000, 1'b0, 3'b000, 1'b1, 8'hA1, 2'd1};
      vecs[12] = '{3'b111, 3'b000, 1'b1, 3'b100, 1'b1, 8'hA2, 2'd2};
      vecs[13] = '{3'b000, 3'b000, 1'b1, 3'b000, 1'b0, 8'h00, 2'd2};
      vecs[14] = '{3'b010, 3'b000, 1'b1, 3'b010, 1'b1, 8'hA1, 2'd1};
      vecs[15] = '{3'b000, 3'b000, 1'b1, 3'b000, 1'b0, 8'h00, 2'd1};
      vecs[16] = '{3'b001, 3'b000, 1'b1, 3'b001, 1'b1, 8'hA0, 2'd0};
      vecs[17] = '{3'b100, 3'b000, 1'b0, 3'b000, 1'b1, 8'hA0, 2'd0};
      vecs[18] = '{3'b100, 3'b000, 1'b0, 3'b000, 1'b1, 8'hA0, 2'd0};
      vecs[19] = '{3'b100, 3'b000, 1'b0, 3'b000, 1'b1, 8'hA0, 2'd0};
      vecs[20] = '{3'b000, 3'b000, 1'b0, 3'b000, 1'b1, 8'hA0, 2'd0};
      vecs[21] = '{3'b100, 3'b000, 1'b0, 3'b000, 1'b1, 8'hA0, 2'd0};
      // Requester 2 waited 3 cycles then withdrew; if its age survived it would beat requester 0 here.
      vecs[22] = '{3'b101, 3'b001, 1'b1, 3'b001, 1'b1, 8'hA0, 2'd0};

      age_exp_ack = '{3'b001, 3'b001, 3'b001, 3'b001, 3'b100, 3'b001};
      age_exp_g   = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd2, 2'd0};
      age_exp_out = '{8'hA0, 8'hA0, 8'hA0, 8'hA0, 8'hA2, 8'hA0};

      request_flatted_in          = {8'hA2, 8'hA1, 8'hA0};
      request_valid_flatted_in    = 3'b111;
      request_critical_flatted_in = 3'b000;
      issue_ack_in                = 1'b1;
      reset_in                    = 1'b1;

      repeat (2) @(posedge clk_in);
      #3;
      check("reset.ack", 32'(issue_ack_out), 32'h0);
      check("reset.rv", 32'(request_valid_out), 32'h0);
      check("reset.out", 32'(request_out), 32'h0);
      check("reset.grant", 32'(grant_index_out), 32'h0);
      reset_in = 1'b0;

      for (int v = 0; v < 23; v++) begin
         step($sformatf("vec%0d", v), vecs[v].valid, vecs[v].crit, vecs[v].ack_in,
              vecs[v].exp_ack, vecs[v].exp_rv, vecs[v].exp_out, vecs[v].exp_g);
      end

      // Asynchronous reset between edges while the output stage is full.
      request_valid_flatted_in = 3'b111;
      #2;
      check("midrst.rv_before", 32'(request_valid_out), 32'h1);
      reset_in = 1'b1;
      #1;
      check("midrst.ack", 32'(issue_ack_out), 32'h0);
      check("midrst.rv", 32'(request_valid_out), 32'h0);
      check("midrst.out", 32'(request_out), 32'h0);
      check("midrst.grant", 32'(grant_index_out), 32'h0);
      @(posedge clk_in);
      #3;
      reset_in = 1'b0;
      step("postrst", 3'b111, 3'b000, 1'b1, 3'b001, 1'b1, 8'hA0, 2'd0);

      // Fresh reset, then requester 0 always critical starves requester 2 until it ages.
      reset_in = 1'b1;
      @(posedge clk_in);
      #3;
      reset_in = 1'b0;
      for (int c = 0; c < 6; c++) begin
         step($sformatf("age%0d", c), 3'b101, 3'b001, 1'b1,
              age_exp_ack[c], 1'b1, age_exp_out[c], age_exp_g[c]);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
